// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state encoding and round-constant lookup for the key schedule.
package aes_pkg;

  localparam int KEY_W     = 128;
  localparam int WORD_W    = 32;
  localparam int NR_AES128 = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DONE = 2'd3
  } ks_state_e;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round 0 has no round constant; out-of-range indices read as zero.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    r = 8'h00;
    if (rnd >= 4'd1 && rnd <= 4'd10) r = RCON[rnd];
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Key-load request and round-key stream between the loader, the schedule and the round engine.
interface aes_inv_key_schedule_if;
  import aes_pkg::*;

  logic              start;
  logic [KEY_W-1:0]  key;
  logic              key_is_last;
  logic [KEY_W-1:0]  round_key;
  logic [3:0]        round_idx;
  logic              valid;
  logic              ready;
  logic              busy;
  logic              done;

  modport master (
    output start, key, key_is_last, ready,
    input  round_key, round_idx, valid, busy, done
  );

  modport slave (
    input  start, key, key_is_last, ready,
    output round_key, round_idx, valid, busy, done
  );

endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box computed as GF(2^8) inverse (x^254) followed by the affine transform.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 == x^-1 for nonzero x, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] r;
    t = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  logic [7:0] b;

  always_comb begin
    b = ginv(a);
    s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: one S-box lane per byte, purely combinational.
module aes_sub_word import aes_pkg::*; (
  input  logic [WORD_W-1:0] w,
  output logic [WORD_W-1:0] s
);

  localparam int VEC_W     = 8;
  localparam int NUM_LANES = WORD_W / VEC_W;

  logic [NUM_LANES-1:0][VEC_W-1:0] w_b;
  logic [NUM_LANES-1:0][VEC_W-1:0] s_b;

  assign w_b = w;
  assign s   = s_b;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    aes_sbox u_sbox (
      .a (w_b[l]),
      .s (s_b[l])
    );
  end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 key schedule: walks forward to round 10, then streams round keys 10..0.
module aes_inv_key_schedule import aes_pkg::*; #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  i_Rst_n,
  aes_inv_key_schedule_if.slave ks
);

  if (NR != NR_AES128) begin : g_bad_nr
    $error("aes_inv_key_schedule: NR must be 10 for AES-128");
  end

  localparam logic [3:0] LAST_RND = 4'(NR);

  ks_state_e         state_q, state_d;
  logic [KEY_W-1:0]  key_q;
  logic [3:0]        cnt_q;
  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] n0, n1, n2, n3;
  logic [WORD_W-1:0] p0, p1, p2, p3;
  logic [WORD_W-1:0] sw_in, sw_out, rc_word;
  logic              xfer;

  assign {w0, w1, w2, w3} = key_q;
  assign xfer             = (state_q == ST_REV) && ks.ready;

  // Previous-round words 1..3 fall out of the xor chain; p3 is the word fed to SubWord.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // Single SubWord shared by both walks: RotWord(w3) going forward, RotWord(p3) in reverse.
  assign sw_in   = (state_q == ST_FWD) ? {w3[23:0], w3[31:24]} : {p3[23:0], p3[31:24]};
  assign rc_word = {rcon(cnt_q), 24'h0};

  aes_sub_word u_sub_word (
    .w (sw_in),
    .s (sw_out)
  );

  assign n0 = w0 ^ sw_out ^ rc_word;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign p0 = w0 ^ sw_out ^ rc_word;

  always_ff @(posedge clk) begin
    if (!i_Rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (ks.start) state_d = ks.key_is_last ? ST_REV : ST_FWD;
      ST_FWD:  if (cnt_q == LAST_RND) state_d = ST_REV;
      ST_REV:  if (xfer && cnt_q == 4'd0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ks.valid     = 1'b0;
    ks.round_key = '0;
    ks.round_idx = '0;
    ks.busy      = 1'b1;
    ks.done      = 1'b0;
    unique case (state_q)
      ST_IDLE: ks.busy = 1'b0;
      ST_REV: begin
        ks.valid     = 1'b1;
        ks.round_key = key_q;
        ks.round_idx = cnt_q;
      end
      ST_DONE: ks.done = 1'b1;
      default: ;
    endcase
  end

  // Key and counter only move on a transfer in REV, which keeps the output stable under stall.
  always_ff @(posedge clk) begin
    if (!i_Rst_n) begin
      key_q <= '0;
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (ks.start) begin
          key_q <= ks.key;
          cnt_q <= ks.key_is_last ? LAST_RND : 4'd1;
        end
        ST_FWD: begin
          key_q <= {n0, n1, n2, n3};
          cnt_q <= (cnt_q == LAST_RND) ? LAST_RND : cnt_q + 4'd1;
        end
        ST_REV: if (xfer && cnt_q != 4'd0) begin
          key_q <= {p0, p1, p2, p3};
          cnt_q <= cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for the reverse-order AES-128 key schedule against a table-driven key expansion model.
module tb_aes_inv_key_schedule;

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_A9 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_AL = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_BL = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_inv_key_schedule_if ks ();

  aes_inv_key_schedule #(.NR(10)) dut (
    .clk     (clk),
    .i_Rst_n (rst_n),
    .ks      (ks)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] exp_rk [0:10];
  logic [127:0] cap_key [0:10];
  logic [3:0]   cap_idx [0:10];
  int n_xfer, first_lat, done_gap, unstable, first_x, last_x;

  // S-box table from the generator-3 walk over GF(2^8), independent of any inverse computation.
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  task automatic m_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Drives one start and collects every transfer; ends on the negedge after the DONE cycle.
  task automatic run_seq(input logic [127:0] k, input logic last, input int stall_pct,
                         input int inj_a, input int inj_b, input logic poke_done);
    logic         held, saw_done;
    logic [127:0] hk;
    logic [3:0]   hi;
    n_xfer = 0; first_lat = -1; done_gap = -1; unstable = 0;
    first_x = -1; last_x = 0; held = 1'b0; saw_done = 1'b0; hk = '0; hi = '0;
    for (int j = 0; j < 11; j++) begin cap_key[j] = 'x; cap_idx[j] = 'x; end
    @(negedge clk);
    ks.start = 1'b1; ks.key = k; ks.key_is_last = last; ks.ready = 1'b0;
    for (int c = 1; c <= 400 && !saw_done; c++) begin
      @(negedge clk);
      ks.start = 1'b0;
      if (ks.valid && first_lat < 0) first_lat = c;
      if (held && (!ks.valid || ks.round_key !== hk || ks.round_idx !== hi)) unstable++;
      held = 1'b0;
      if (ks.done) begin
        saw_done = 1'b1;
        done_gap = c - last_x;
        ks.ready = 1'b0;
        if (poke_done) begin ks.start = 1'b1; ks.key = ~k; ks.key_is_last = ~last; end
      end else begin
        ks.ready = ($urandom_range(99) >= stall_pct);
        if (c == inj_a || c == inj_b) begin ks.start = 1'b1; ks.key = ~k; ks.key_is_last = ~last; end
        if (ks.valid && ks.ready) begin
          if (n_xfer < 11) begin cap_key[n_xfer] = ks.round_key; cap_idx[n_xfer] = ks.round_idx; end
          if (first_x < 0) first_x = c;
          n_xfer++;
          last_x = c;
        end else if (ks.valid) begin
          held = 1'b1; hk = ks.round_key; hi = ks.round_idx;
        end
      end
    end
    @(negedge clk);
    ks.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ks.start = 1'b0; ks.key = '0; ks.key_is_last = 1'b0; ks.ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ks.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ks.valid); end
    total++; if (ks.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", ks.busy); end
    total++; if (ks.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", ks.done); end
    total++; if (ks.round_key !== 128'h0) begin bad++; $display("FAIL reset_key: got %h want 0", ks.round_key); end
    total++; if (ks.round_idx !== 4'h0) begin bad++; $display("FAIL reset_idx: got %0d want 0", ks.round_idx); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fwd_vector();
    m_expand(KEY_A);
    run_seq(KEY_A, 1'b0, 0, -1, -1, 1'b0);
    total++; if (first_lat != 11) begin bad++; $display("FAIL fwd_latency: got %0d want 11", first_lat); end
    total++; if (n_xfer != 11) begin bad++; $display("FAIL fwd_count: got %0d want 11", n_xfer); end
    for (int j = 0; j < 11; j++) begin
      total++;
      if (cap_idx[j] !== 4'(10 - j) || cap_key[j] !== exp_rk[10-j]) begin
        bad++; $display("FAIL fwd_seq[%0d]: got idx=%0d key=%h want idx=%0d key=%h", j, cap_idx[j], cap_key[j], 10 - j, exp_rk[10-j]);
      end
    end
    total++; if (cap_key[0] !== KEY_AL) begin bad++; $display("FAIL fwd_idx10: got %h want %h", cap_key[0], KEY_AL); end
    total++; if (cap_key[9] !== KEY_A9) begin bad++; $display("FAIL fwd_idx1: got %h want %h", cap_key[9], KEY_A9); end
    total++; if (cap_key[10] !== KEY_A) begin bad++; $display("FAIL fwd_idx0: got %h want %h", cap_key[10], KEY_A); end
    total++; if (done_gap != 1) begin bad++; $display("FAIL fwd_done_gap: got %0d want 1", done_gap); end
    total++; if (last_x - first_x != 10) begin bad++; $display("FAIL back_to_back: got span %0d want 10", last_x - first_x); end
    total++; if (ks.busy !== 1'b0) begin bad++; $display("FAIL fwd_idle_busy: got %b want 0", ks.busy); end
  endtask

  task automatic test_last_key();
    m_expand(KEY_A);
    run_seq(KEY_AL, 1'b1, 0, -1, -1, 1'b0);
    total++; if (first_lat != 1) begin bad++; $display("FAIL last_latency: got %0d want 1", first_lat); end
    total++; if (n_xfer != 11) begin bad++; $display("FAIL last_count: got %0d want 11", n_xfer); end
    for (int j = 0; j < 11; j++) begin
      total++;
      if (cap_idx[j] !== 4'(10 - j) || cap_key[j] !== exp_rk[10-j]) begin
        bad++; $display("FAIL last_seq[%0d]: got idx=%0d key=%h want idx=%0d key=%h", j, cap_idx[j], cap_key[j], 10 - j, exp_rk[10-j]);
      end
    end
    total++; if (done_gap != 1) begin bad++; $display("FAIL last_done_gap: got %0d want 1", done_gap); end
  endtask

  task automatic test_stall();
    m_expand(KEY_A);
    run_seq(KEY_A, 1'b0, 50, -1, -1, 1'b0);
    total++; if (n_xfer != 11) begin bad++; $display("FAIL stall_count: got %0d want 11", n_xfer); end
    total++; if (unstable != 0) begin bad++; $display("FAIL stall_hold: got %0d changes want 0", unstable); end
    for (int j = 0; j < 11; j++) begin
      total++;
      if (cap_idx[j] !== 4'(10 - j) || cap_key[j] !== exp_rk[10-j]) begin
        bad++; $display("FAIL stall_seq[%0d]: got idx=%0d key=%h want idx=%0d key=%h", j, cap_idx[j], cap_key[j], 10 - j, exp_rk[10-j]);
      end
    end
    total++; if (done_gap != 1) begin bad++; $display("FAIL stall_done_gap: got %0d want 1", done_gap); end
  endtask

  task automatic test_start_ignored();
    m_expand(KEY_A);
    run_seq(KEY_A, 1'b0, 0, 5, 15, 1'b1);
    total++; if (n_xfer != 11) begin bad++; $display("FAIL ign_count: got %0d want 11", n_xfer); end
    for (int j = 0; j < 11; j++) begin
      total++;
      if (cap_idx[j] !== 4'(10 - j) || cap_key[j] !== exp_rk[10-j]) begin
        bad++; $display("FAIL ign_seq[%0d]: got idx=%0d key=%h want idx=%0d key=%h", j, cap_idx[j], cap_key[j], 10 - j, exp_rk[10-j]);
      end
    end
    repeat (2) begin
      total++;
      if (ks.busy !== 1'b0 || ks.valid !== 1'b0) begin
        bad++; $display("FAIL ign_done_start: got busy=%b valid=%b want 0 0", ks.busy, ks.valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    logic found;
    found = 1'b0;
    @(negedge clk);
    ks.start = 1'b1; ks.key = KEY_A; ks.key_is_last = 1'b0; ks.ready = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      ks.start = 1'b0;
      if (ks.valid && ks.round_idx == 4'd5) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL rst_reach_idx5: got timeout want idx 5"); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (ks.valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", ks.valid); end
    total++; if (ks.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", ks.busy); end
    total++; if (ks.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", ks.done); end
    total++; if (ks.round_key !== 128'h0) begin bad++; $display("FAIL rst_key: got %h want 0", ks.round_key); end
    total++; if (ks.round_idx !== 4'h0) begin bad++; $display("FAIL rst_idx: got %0d want 0", ks.round_idx); end
    repeat (3) begin
      @(negedge clk);
      total++; if (ks.valid !== 1'b0) begin bad++; $display("FAIL rst_no_partial: got valid=%b want 0", ks.valid); end
    end
    m_expand(KEY_A);
    run_seq(KEY_A, 1'b0, 0, -1, -1, 1'b0);
    total++; if (n_xfer != 11) begin bad++; $display("FAIL rst_rerun_count: got %0d want 11", n_xfer); end
    for (int j = 0; j < 11; j++) begin
      total++;
      if (cap_idx[j] !== 4'(10 - j) || cap_key[j] !== exp_rk[10-j]) begin
        bad++; $display("FAIL rst_rerun_seq[%0d]: got idx=%0d key=%h want idx=%0d key=%h", j, cap_idx[j], cap_key[j], 10 - j, exp_rk[10-j]);
      end
    end
  endtask

  task automatic test_zero_key();
    m_expand(KEY_B);
    run_seq(KEY_B, 1'b0, 20, -1, -1, 1'b0);
    total++; if (cap_key[0] !== KEY_BL) begin bad++; $display("FAIL zk_idx10: got %h want %h", cap_key[0], KEY_BL); end
    total++; if (cap_key[10] !== KEY_B) begin bad++; $display("FAIL zk_idx0: got %h want %h", cap_key[10], KEY_B); end
    for (int j = 0; j < 11; j++) begin
      total++;
      if (cap_idx[j] !== 4'(10 - j) || cap_key[j] !== exp_rk[10-j]) begin
        bad++; $display("FAIL zk_seq[%0d]: got idx=%0d key=%h want idx=%0d key=%h", j, cap_idx[j], cap_key[j], 10 - j, exp_rk[10-j]);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] k0;
    logic         last;
    for (int t = 0; t < 6; t++) begin
      k0   = {$urandom(), $urandom(), $urandom(), $urandom()};
      last = 1'($urandom_range(1));
      m_expand(k0);
      run_seq(last ? exp_rk[10] : k0, last, 30, -1, -1, 1'b0);
      total++; if (first_lat != (last ? 1 : 11)) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", t, first_lat, last ? 1 : 11); end
      total++; if (n_xfer != 11 || unstable != 0) begin bad++; $display("FAIL rnd_count[%0d]: got n=%0d unstable=%0d want 11 0", t, n_xfer, unstable); end
      for (int j = 0; j < 11; j++) begin
        total++;
        if (cap_idx[j] !== 4'(10 - j) || cap_key[j] !== exp_rk[10-j]) begin
          bad++; $display("FAIL rnd_seq[%0d][%0d]: got idx=%0d key=%h want idx=%0d key=%h", t, j, cap_idx[j], cap_key[j], 10 - j, exp_rk[10-j]);
        end
      end
    end
  endtask

  initial begin
    init_sbox();
    test_reset();
    test_fwd_vector();
    test_last_key();
    test_stall();
    test_start_ignored();
    test_mid_reset();
    test_zero_key();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
